// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and default timing for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 4;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read side plus serial line and status, bundled between transmitter and its environment.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic                 tx_enable;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_read_en;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  tx_enable, fifo_empty, fifo_data,
        output fifo_read_en, tx, busy, frame_done
    );

    modport slave (
        output tx_enable, fifo_empty, fifo_data,
        input  fifo_read_en, tx, busy, frame_done
    );

endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, ticks on the last count, restarts on clear.
module baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from a registered-output sync FIFO.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master bus
);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tick;
    logic                 clear;
    logic                 can_start;

    // Only consulted from IDLE and the last STOP cycle.
    assign can_start = bus.tx_enable && !bus.fifo_empty;
    assign clear     = (state_d != state_q);

    baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE:  if (can_start) state_d = ST_POP;
            ST_POP:   state_d = ST_LOAD;
            ST_LOAD: begin
                // FIFO read data is valid the cycle after the pop.
                shift_d = bus.fifo_data;
                state_d = ST_START;
            end
            ST_START: if (tick) begin
                idx_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA:  if (tick) begin
                shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP:  if (tick) state_d = can_start ? ST_POP : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.tx           = 1'b1;
        bus.fifo_read_en = 1'b0;
        bus.frame_done   = 1'b0;
        bus.busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_POP:   bus.fifo_read_en = 1'b1;
            ST_START: bus.tx           = 1'b0;
            ST_DATA:  bus.tx           = shift_q[0];
            ST_STOP:  bus.frame_done   = tick;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame scoreboard, table vectors and random traffic.
module tb_fifo_uart_tx;

    localparam int N  = 4;
    localparam int FL = 10 * N;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_uart_tx_if bus ();
    fifo_uart_tx_if bus2 ();

    fifo_uart_tx #(.CLKS_PER_BIT(N)) u_dut  (.clk(clk), .reset(rst_n), .bus(bus));
    fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

    // 8x8 synchronous FIFO with registered read data
    logic [7:0] fmem [8];
    logic [2:0] fwp, frp;
    logic [3:0] fcnt;
    logic [7:0] rdata_q;
    logic       fifo_clr, wr_en;
    logic [7:0] wr_data;
    logic       f_push, f_pop;

    assign f_push = wr_en && (fcnt < 4'd8);
    assign f_pop  = bus.fifo_read_en && (fcnt != 4'd0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fwp <= '0; frp <= '0; fcnt <= '0; rdata_q <= '0;
        end else begin
            if (f_push) begin fmem[fwp] <= wr_data; fwp <= fwp + 3'd1; end
            if (f_pop)  begin rdata_q <= fmem[frp]; frp <= frp + 3'd1; end
            fcnt <= fcnt + {3'b0, f_push} - {3'b0, f_pop};
        end
    end

    assign bus.fifo_empty = (fcnt == 4'd0);
    assign bus.fifo_data  = rdata_q;

    int pops_seen = 0, done_seen = 0, pops2 = 0, want2 = 0;
    always @(posedge clk) begin
        if (bus.fifo_read_en)  pops_seen <= pops_seen + 1;
        if (bus.frame_done)    done_seen <= done_seen + 1;
        if (bus2.fifo_read_en) pops2     <= pops2 + 1;
    end
    assign bus2.fifo_empty = (pops2 >= want2);
    assign bus2.fifo_data  = 8'h01;

    int total = 0, bad = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ideal line waveform of one frame, one entry per clock, index 0 = first start cycle
    function automatic logic [63:0] frame_wave(input logic [7:0] b, input int n);
        logic [63:0] w;
        int slot;
        w = '0;
        for (int i = 0; i < 10 * n; i++) begin
            slot = i / n;
            if (slot == 0)      w[i] = 1'b0;
            else if (slot == 9) w[i] = 1'b1;
            else                w[i] = b[slot-1];
        end
        return w;
    endfunction

    task automatic push(input logic [7:0] b);
        @(negedge clk); wr_en = 1'b1; wr_data = b;
        @(negedge clk); wr_en = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic wait_start(input int limit, output int gap, output bit ok, output int busy_low);
        gap = 0; ok = 1'b0; busy_low = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin ok = 1'b1; break; end
            gap++;
            if (bus.busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic check_frame(input int drop_at, output int gap, output logic [9:0] pat,
                               output int gap_busy_low);
        bit ok;
        logic [63:0] obs, fd, bz;
        logic [7:0]  eb;
        int p0;
        obs = '0; fd = '0; bz = '0; pat = '0;
        wait_start(400, gap, ok, gap_busy_low);
        chk("frame_start_seen", 64'(ok), 64'(1));
        if (!ok) return;
        p0 = pops_seen;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            obs[i] = bus.tx; fd[i] = bus.frame_done; bz[i] = bus.busy;
            if (i == drop_at) bus.tx_enable = 1'b0;
        end
        for (int s = 0; s < 10; s++) pat[9-s] = obs[s*N + N/2];
        if (exp_q.size() == 0) begin
            chk("scoreboard_has_byte", 64'(0), 64'(1));
            return;
        end
        eb = exp_q.pop_front();
        chk("frame_wave", obs, frame_wave(eb, N));
        chk("frame_done_pos", fd, 64'd1 << (FL - 1));
        chk("busy_in_frame", bz, (64'd1 << FL) - 64'd1);
        chk("no_pop_in_frame", 64'(pops_seen - p0), 64'(0));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int gap, gbl, p0, d0, txlow, bsy, nb;
        bit ok;
        logic [9:0] pat;
        logic [63:0] obs, fd;

        vecs[0] = '{data: 8'hA5, bits: 10'b0101001011};
        vecs[1] = '{data: 8'h00, bits: 10'b0000000001};
        vecs[2] = '{data: 8'hFF, bits: 10'b0111111111};
        vecs[3] = '{data: 8'h3C, bits: 10'b0001111001};
        vecs[4] = '{data: 8'h81, bits: 10'b0100000011};

        rst_n = 1'b0; fifo_clr = 1'b1; wr_en = 1'b0; wr_data = '0;
        bus.tx_enable = 1'b0; bus2.tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        fifo_clr = 1'b0;

        // Reset held with data pending and enable high
        bus.tx_enable = 1'b1;
        push(8'h3C);
        repeat (2) @(negedge clk);
        chk("rst_tx", 64'(bus.tx), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
        chk("rst_read_en", 64'(bus.fifo_read_en), 64'(0));
        chk("rst_no_pops", 64'(pops_seen), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_pop_at_first_edge", 64'(fcnt), 64'(1));
        check_frame(-1, gap, pat, gbl);
        bus.tx_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Table vectors: single frame each
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].data);
            p0 = pops_seen; d0 = done_seen;
            bus.tx_enable = 1'b1;
            check_frame(-1, gap, pat, gbl);
            bus.tx_enable = 1'b0;
            repeat (4) @(negedge clk);
            chk("vec_bits", 64'(pat), 64'(vecs[v].bits));
            chk("vec_one_pop", 64'(pops_seen - p0), 64'(1));
            chk("vec_one_done", 64'(done_seen - d0), 64'(1));
            chk("vec_fifo_drained", 64'(fcnt), 64'(0));
            chk("vec_idle_tx", 64'(bus.tx), 64'(1));
            chk("vec_idle_busy", 64'(bus.busy), 64'(0));
        end

        // Empty FIFO with enable high
        p0 = pops_seen; txlow = 0; bsy = 0;
        bus.tx_enable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) txlow++;
            if (bus.busy !== 1'b0) bsy++;
        end
        bus.tx_enable = 1'b0;
        chk("empty_no_pop", 64'(pops_seen - p0), 64'(0));
        chk("empty_tx_high", 64'(txlow), 64'(0));
        chk("empty_not_busy", 64'(bsy), 64'(0));

        // Back-to-back frames
        push(8'h00); push(8'hFF); push(8'h3C);
        d0 = done_seen;
        bus.tx_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            check_frame(-1, gap, pat, gbl);
            if (f > 0) begin
                chk("b2b_gap", 64'(gap), 64'(2));
                chk("b2b_gap_busy", 64'(gbl), 64'(0));
            end
        end
        bus.tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done_count", 64'(done_seen - d0), 64'(3));

        // Full FIFO, gated by enable, enable dropped during frame 3
        for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
        p0 = pops_seen;
        repeat (20) @(negedge clk);
        chk("full_no_pop", 64'(pops_seen - p0), 64'(0));
        chk("full_count", 64'(fcnt), 64'(8));
        bus.tx_enable = 1'b1;
        for (int f = 0; f < 3; f++) check_frame((f == 2) ? FL / 2 : -1, gap, pat, gbl);
        p0 = pops_seen; txlow = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) txlow++;
        end
        chk("drop_no_frame4_pop", 64'(pops_seen - p0), 64'(0));
        chk("drop_no_frame4_tx", 64'(txlow), 64'(0));
        chk("drop_fifo_left", 64'(fcnt), 64'(5));
        chk("drop_idle", 64'(bus.busy), 64'(0));
        bus.tx_enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            check_frame(-1, gap, pat, gbl);
            if (f > 0) chk("resume_gap", 64'(gap), 64'(2));
        end
        bus.tx_enable = 1'b0;
        repeat (3) @(negedge clk);

        // Random bursts
        for (int r = 0; r < 4; r++) begin
            nb = int'($urandom_range(1, 8));
            for (int k = 0; k < nb; k++) push(8'($urandom));
            repeat ($urandom_range(0, 10)) @(negedge clk);
            bus.tx_enable = 1'b1;
            for (int f = 0; f < nb; f++) begin
                check_frame(-1, gap, pat, gbl);
                if (f > 0) chk("rand_gap", 64'(gap), 64'(2));
            end
            bus.tx_enable = 1'b0;
            repeat (3) @(negedge clk);
            chk("rand_drained", 64'(fcnt), 64'(0));
            chk("rand_idle", 64'(bus.busy), 64'(0));
        end

        // Reset during data bit 4 of 0x81
        push(8'h81); push(8'h5A);
        bus.tx_enable = 1'b1;
        wait_start(100, gap, ok, gbl);
        chk("rst_mid_start_seen", 64'(ok), 64'(1));
        repeat (5 * N) @(negedge clk);
        chk("rst_mid_bit4_low", 64'(bus.tx), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 64'(bus.tx), 64'(1));
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        chk("rst_mid_fifo", 64'(fcnt), 64'(1));
        rst_n = 1'b1;
        check_frame(-1, gap, pat, gbl);
        bus.tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_drained", 64'(fcnt), 64'(0));

        // Two clocks per bit instance, byte 0x01
        want2 = 1;
        bus2.tx_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus2.tx === 1'b0) begin ok = 1'b1; break; end
        end
        chk("n2_start_seen", 64'(ok), 64'(1));
        obs = '0; fd = '0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            obs[i] = bus2.tx; fd[i] = bus2.frame_done;
        end
        @(negedge clk);
        chk("n2_wave", obs, frame_wave(8'h01, 2));
        chk("n2_bit0_high", 64'(obs[3:2]), 64'(2'b11));
        chk("n2_done_pos", fd, 64'd1 << 19);
        chk("n2_after_tx", 64'(bus2.tx), 64'(1));
        chk("n2_after_busy", 64'(bus2.busy), 64'(0));
        chk("n2_pops", 64'(pops2), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
